// File: rtl/legv8_pkg.sv
// Shared widths and the ID/EX entry layout for the LEGv8 decode/execute boundary.
package legv8_pkg;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int CTRL_W = 16;
   localparam logic [ADDR_W-1:0] ZR_REG = 5'd31;

   // One buffered instruction: register numbers, operands and opaque control.
   typedef struct packed {
      logic [ADDR_W-1:0] ra1;
      logic [ADDR_W-1:0] ra2;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [CTRL_W-1:0] ctrl;
   } idex_entry_t;

endpackage

// File: rtl/operand_snoop.sv
// Combinational writeback snoop for one operand: replaces the operand with the
// regfile write data when the write targets its source register. XZR is never
// bypassed.
module operand_snoop
   import legv8_pkg::*;
(
   input  logic              en,
   input  logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] op,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   output logic [DATA_W-1:0] op_o
);

   logic hit;

   // Bypass only live entries, and never through the zero register.
   always_comb begin
      hit  = en && wb_we && (wb_wa == ra) && (ra != ZR_REG);
      op_o = hit ? wb_wd : op;
   end

endmodule

// File: rtl/idex_operand_buffer.sv
// Two-entry ID/EX skid buffer (HEAD drives outputs, SKID absorbs one extra
// instruction). Every held operand snoops the regfile write port so it stays
// coherent with writebacks that land while it waits for execute.
module idex_operand_buffer
   import legv8_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_ra1,
   input  logic [ADDR_W-1:0] in_ra2,
   input  logic [DATA_W-1:0] in_rd1,
   input  logic [DATA_W-1:0] in_rd2,
   input  logic [ADDR_W-1:0] in_wa,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_ra1,
   output logic [ADDR_W-1:0] out_ra2,
   output logic [ADDR_W-1:0] out_wa,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [CTRL_W-1:0] out_ctrl
);

   idex_entry_t head_q, head_d, skid_q, skid_d;
   logic        head_vld_q, head_vld_d;
   logic        skid_vld_q, skid_vld_d;
   logic        in_ready_q, in_ready_d;

   idex_entry_t cap_e, head_snp, skid_snp;
   logic [DATA_W-1:0] cap_rd1, cap_rd2;
   logic        accept, pop;

   // XZR reads as zero regardless of what the regfile port shows.
   always_comb begin
      cap_rd1 = (in_ra1 == ZR_REG) ? '0 : in_rd1;
      cap_rd2 = (in_ra2 == ZR_REG) ? '0 : in_rd2;
   end

   // Capture path: a write on the same edge must win over the stale read data.
   operand_snoop u_cap1 (.en(1'b1), .ra(in_ra1), .op(cap_rd1), .wb_we(wb_we),
                         .wb_wa(wb_wa), .wb_wd(wb_wd), .op_o(cap_e.op1));
   operand_snoop u_cap2 (.en(1'b1), .ra(in_ra2), .op(cap_rd2), .wb_we(wb_we),
                         .wb_wa(wb_wa), .wb_wd(wb_wd), .op_o(cap_e.op2));

   // Hold path for the two stored entries; invalid entries are left alone.
   operand_snoop u_head1 (.en(head_vld_q), .ra(head_q.ra1), .op(head_q.op1), .wb_we(wb_we),
                          .wb_wa(wb_wa), .wb_wd(wb_wd), .op_o(head_snp.op1));
   operand_snoop u_head2 (.en(head_vld_q), .ra(head_q.ra2), .op(head_q.op2), .wb_we(wb_we),
                          .wb_wa(wb_wa), .wb_wd(wb_wd), .op_o(head_snp.op2));
   operand_snoop u_skid1 (.en(skid_vld_q), .ra(skid_q.ra1), .op(skid_q.op1), .wb_we(wb_we),
                          .wb_wa(wb_wa), .wb_wd(wb_wd), .op_o(skid_snp.op1));
   operand_snoop u_skid2 (.en(skid_vld_q), .ra(skid_q.ra2), .op(skid_q.op2), .wb_we(wb_we),
                          .wb_wa(wb_wa), .wb_wd(wb_wd), .op_o(skid_snp.op2));

   // Non-operand fields pass straight through; snooping never touches them.
   always_comb begin
      cap_e.ra1     = in_ra1;
      cap_e.ra2     = in_ra2;
      cap_e.wa      = in_wa;
      cap_e.ctrl    = in_ctrl;
      head_snp.ra1  = head_q.ra1;
      head_snp.ra2  = head_q.ra2;
      head_snp.wa   = head_q.wa;
      head_snp.ctrl = head_q.ctrl;
      skid_snp.ra1  = skid_q.ra1;
      skid_snp.ra2  = skid_q.ra2;
      skid_snp.wa   = skid_q.wa;
      skid_snp.ctrl = skid_q.ctrl;
   end

   assign accept = in_valid && in_ready_q;
   assign pop    = head_vld_q && out_ready;

   // Occupancy transitions; a SKID->HEAD move carries the already-snooped SKID
   // so a writeback on that same edge is not lost.
   always_comb begin
      head_d     = head_snp;
      skid_d     = skid_snp;
      head_vld_d = head_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         head_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!head_vld_q) begin
         if (accept) begin
            head_d     = cap_e;
            head_vld_d = 1'b1;
         end
      end else if (!skid_vld_q) begin
         if (accept && pop) begin
            head_d = cap_e;
         end else if (accept) begin
            skid_d     = cap_e;
            skid_vld_d = 1'b1;
         end else if (pop) begin
            head_vld_d = 1'b0;
         end
      end else if (pop) begin
         head_d     = skid_snp;
         skid_vld_d = 1'b0;
      end
      // Registered ready: decode never sees a combinational path from out_ready.
      in_ready_d = !skid_vld_d;
   end

   // State registers; reset clears every field so outputs read zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q     <= '0;
         skid_q     <= '0;
         head_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         head_q     <= head_d;
         skid_q     <= skid_d;
         head_vld_q <= head_vld_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = head_vld_q;
   assign out_ra1   = head_q.ra1;
   assign out_ra2   = head_q.ra2;
   assign out_wa    = head_q.wa;
   assign out_op1   = head_q.op1;
   assign out_op2   = head_q.op2;
   assign out_ctrl  = head_q.ctrl;

endmodule

// File: doc/idex_operand_buffer.md
Name: idex_operand_buffer

Overview:
- Decode-to-execute operand stage, directly downstream of the 32x64 LEGv8 register file (X31 = XZR).
- Captures both read-port values, source/destination register numbers and control bits into a two-entry skid buffer with a valid/ready handshake toward execute.
- Snoops the regfile write port so that every operand it holds stays coherent with later writebacks. This covers the same-edge write and any writeback that lands while an entry is stalled.

Parameters:
- DATA_W, 64, operand width.
- ADDR_W, 5, register-number width.
- CTRL_W, 16, opaque control bundle width, passed through unmodified.
- ZR_REG, 31, register number that always reads zero and is never bypassed.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  buffer can accept; registered output.
- in_ra1, in_ra2  in  ADDR_W  source register numbers, same as regfile ra1/ra2.
- in_rd1, in_rd2  in  DATA_W  regfile read data rd1/rd2.
- in_wa  in  ADDR_W  destination register number.
- in_ctrl  in  CTRL_W  control bundle.
- wb_we  in  1  snoop of regfile we3.
- wb_wa  in  ADDR_W  snoop of regfile wa3.
- wb_wd  in  DATA_W  snoop of regfile wd3.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute accepts the head entry.
- out_ra1, out_ra2, out_wa  out  ADDR_W  head entry register numbers.
- out_op1, out_op2  out  DATA_W  head entry operands, coherent with writebacks.
- out_ctrl  out  CTRL_W  head entry control bundle.

Behaviour:
- Storage is two entries, HEAD (drives the outputs) and SKID, each holding a valid bit plus all fields.
- Reset (reset=0, asynchronous):
  - both valid bits 0;
  - all stored fields 0, so out_* = 0 and out_valid = 0;
  - in_ready = 1.
- Accept event: in_valid & in_ready at posedge. Pop event: out_valid & out_ready at posedge.
- in_ready = !SKID.valid, registered, so decode sees no combinational path from out_ready.
- Occupancy transitions, evaluated at each posedge:
  - EMPTY + accept -> HEAD loaded; out_valid = 1 the next cycle (1-cycle latency).
  - ONE + accept, no pop -> SKID loaded; in_ready = 0 the next cycle.
  - ONE + accept + pop -> HEAD reloaded with the new entry.
  - ONE + pop -> EMPTY.
  - TWO + pop -> SKID moves to HEAD; in_ready = 1 the next cycle.
  - TWO + no pop -> hold.
- Capture bypass, per operand:
  - If wb_we & wb_wa == in_raN & in_raN != ZR_REG, the stored operand is wb_wd; otherwise it is in_rdN.
  - If in_raN == ZR_REG, the stored operand is forced to 0 regardless of in_rdN.
- Hold bypass: every valid stored entry with raN == wb_wa, raN != ZR_REG and wb_we = 1 replaces opN with wb_wd at the posedge. This applies on the same edge as a SKID->HEAD move, using the moved entry's raN.
- wb_wa == ZR_REG never modifies any operand.
- out_ra*, out_wa and out_ctrl are never modified by snooping.
- flush = 1 at posedge:
  - both valid bits clear;
  - a simultaneous accept is discarded;
  - in_ready = 1 the next cycle;
  - data fields may keep stale values.
- out_valid drops only on pop or flush. While out_valid = 1 and out_ready = 0, out_ra*, out_wa and out_ctrl are stable; out_op* may change only through the hold bypass.
- Reset asserted mid-transfer: the state is lost immediately. There is no partial pop.

Decomposition:
- Shared package (legv8_pkg) holds DATA_W, ADDR_W, ZR_REG and a packed struct idex_entry_t {ra1, ra2, wa, op1, op2, ctrl}.
- One sub-module, operand_snoop, is natural: a combinational per-entry operand update from (ra, op, wb_we, wb_wa, wb_wd). It is instantiated once per operand for the capture path, HEAD and SKID.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> out_valid=0, in_ready=1, out_op1=out_op2=0.
- Simple pass: accept {ra1=3, rd1=0x11, ra2=4, rd2=0x22, wa=5}, out_ready=1 -> next cycle out_valid=1, out_op1=0x11, out_op2=0x22, out_wa=5; the cycle after -> out_valid=0.
- Capture bypass:
  - accept ra1=7, rd1=0xAAAA while wb_we=1, wb_wa=7, wb_wd=0x1234 -> out_op1=0x1234;
  - repeat with ra1=31, wb_wa=31 -> out_op1=0.
- Backpressure and skid:
  - out_ready=0, accept A then B -> in_ready=0, out_* show A;
  - raise out_ready -> A pops, B is at head and in_ready=1 the next cycle;
  - no entry lost or duplicated.
- Hold bypass: stall entry ra2=9, op2=0x5, then wb_we=1, wb_wa=9, wb_wd=0xBEEF -> out_op2=0xBEEF the next cycle while out_valid stays 1; a further write with wb_wa=31 leaves it unchanged.
- Flush: with TWO entries, assert flush together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the accepted instruction never appears.
